// File: rtl/segment_switch_ctl.sv
// Segment switch controller: latches a segment-switch request, waits for its trigger, then runs
// the new segment for a finite or infinite loop count. Optional GPIO trigger: SEGMENT_SWITCH_GPIO_EN.
module segment_switch_ctl #(
    parameter int unsigned SysTimeWidth = 56,
    parameter int unsigned RepWidth     = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    UPDATE,
    input  logic                    REQ_SEGMENT,
    input  logic [RepWidth-1:0]     REP,
    input  logic [7:0]              TRANSITION_MODE,
    input  logic [63:0]             TRANSITION_VALUE,
    input  logic [SysTimeWidth-1:0] SYS_TIME,
    input  logic [3:0]              GPIO_IN,
    input  logic                    LOOP_END,
    output logic                    SEGMENT,
    output logic                    STOP,
    output logic                    PENDING,
    output logic                    SWAP,
    output logic                    INVALID
);

    localparam logic [7:0] ModeSyncIdx = 8'h00;
    localparam logic [7:0] ModeSysTime = 8'h01;
    localparam logic [7:0] ModeGpio    = 8'h02;
    localparam logic [7:0] ModeExt     = 8'hF0;

    typedef enum logic [2:0] {
        StWaitStart,
        StRunInfinite,
        StRunFinite,
        StStopped,
        StExtSwap
    } state_e;

    state_e                  state_q, state_d;
    logic                    req_seg_q, req_seg_d;
    logic [RepWidth-1:0]     rep_q, rep_d;
    logic [7:0]              mode_q, mode_d;
    logic [SysTimeWidth-1:0] value_q, value_d;
    logic [RepWidth-1:0]     cnt_q, cnt_d;
    logic                    segment_q, segment_d;
    logic                    stop_q, stop_d;
    logic                    pending_q, pending_d;
    logic                    swap_q, swap_d;
    logic                    invalid_q, invalid_d;

    logic mode_ok;
    logic trig;

`ifdef SEGMENT_SWITCH_GPIO_EN
    assign mode_ok = (TRANSITION_MODE == ModeSyncIdx) || (TRANSITION_MODE == ModeSysTime) ||
                     (TRANSITION_MODE == ModeGpio) || (TRANSITION_MODE == ModeExt);
    logic unused_inputs;
    assign unused_inputs = ^TRANSITION_VALUE;
`else
    assign mode_ok = (TRANSITION_MODE == ModeSyncIdx) || (TRANSITION_MODE == ModeSysTime) ||
                     (TRANSITION_MODE == ModeExt);
    // GPIO_IN has no functional path in this build.
    logic unused_inputs;
    assign unused_inputs = ^{TRANSITION_VALUE, GPIO_IN};
`endif

    always_comb begin
        trig = 1'b0;
        case (mode_q)
            ModeSyncIdx: trig = LOOP_END;
            ModeSysTime: trig = (SYS_TIME >= value_q);
`ifdef SEGMENT_SWITCH_GPIO_EN
            ModeGpio:    trig = GPIO_IN[value_q[1:0]];
`endif
            ModeExt:     trig = 1'b1;
            default:     trig = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        req_seg_d = req_seg_q;
        rep_d     = rep_q;
        mode_d    = mode_q;
        value_d   = value_q;
        cnt_d     = cnt_q;
        segment_d = segment_q;
        stop_d    = stop_q;
        pending_d = pending_q;
        swap_d    = 1'b0;
        invalid_d = 1'b0;

        // A new request outranks any trigger or loop-end seen in the same cycle.
        if (UPDATE) begin
            if (mode_ok) begin
                req_seg_d = REQ_SEGMENT;
                rep_d     = REP;
                mode_d    = TRANSITION_MODE;
                value_d   = TRANSITION_VALUE[SysTimeWidth-1:0];
                pending_d = 1'b1;
                state_d   = StWaitStart;
            end else begin
                invalid_d = 1'b1;
            end
        end else begin
            case (state_q)
                StWaitStart: begin
                    if (trig) begin
                        segment_d = req_seg_q;
                        swap_d    = 1'b1;
                        pending_d = 1'b0;
                        stop_d    = 1'b0;
                        cnt_d     = '0;
                        if (mode_q == ModeExt) begin
                            state_d = StExtSwap;
                        end else if (&rep_q) begin
                            state_d = StRunInfinite;
                        end else begin
                            state_d = StRunFinite;
                        end
                    end
                end
                StRunFinite: begin
                    if (LOOP_END) begin
                        if (cnt_q == rep_q) begin
                            stop_d  = 1'b1;
                            state_d = StStopped;
                        end else begin
                            cnt_d = cnt_q + RepWidth'(1);
                        end
                    end
                end
                StExtSwap: begin
                    if (LOOP_END) begin
                        segment_d = ~segment_q;
                        swap_d    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StRunInfinite;
            req_seg_q <= 1'b0;
            rep_q     <= '0;
            mode_q    <= ModeSyncIdx;
            value_q   <= '0;
            cnt_q     <= '0;
            segment_q <= 1'b0;
            stop_q    <= 1'b0;
            pending_q <= 1'b0;
            swap_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_seg_q <= req_seg_d;
            rep_q     <= rep_d;
            mode_q    <= mode_d;
            value_q   <= value_d;
            cnt_q     <= cnt_d;
            segment_q <= segment_d;
            stop_q    <= stop_d;
            pending_q <= pending_d;
            swap_q    <= swap_d;
            invalid_q <= invalid_d;
        end
    end

    assign SEGMENT = segment_q;
    assign STOP    = stop_q;
    assign PENDING = pending_q;
    assign SWAP    = swap_q;
    assign INVALID = invalid_q;

endmodule

// File: tb/tb_segment_switch_ctl.sv
// Bench for segment_switch_ctl: directed scenarios plus randomized traffic, all checked against
// a request/loop-budget reference model. Honours SEGMENT_SWITCH_GPIO_EN like the design.
module tb_segment_switch_ctl;

    localparam int SW = 56;
    localparam int RW = 16;
`ifdef SEGMENT_SWITCH_GPIO_EN
    localparam bit GpioEn = 1'b1;
`else
    localparam bit GpioEn = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          UPDATE = 1'b0;
    logic          REQ_SEGMENT = 1'b0;
    logic [RW-1:0] REP = '0;
    logic [7:0]    TRANSITION_MODE = 8'h00;
    logic [63:0]   TRANSITION_VALUE = '0;
    logic [SW-1:0] SYS_TIME = '0;
    logic [3:0]    GPIO_IN = '0;
    logic          LOOP_END = 1'b0;
    logic          SEGMENT, STOP, PENDING, SWAP, INVALID;

    int n_checks = 0;
    int n_fail   = 0;

    segment_switch_ctl #(.SysTimeWidth(SW), .RepWidth(RW)) dut (
        .CLK(CLK), .RST(RST), .UPDATE(UPDATE), .REQ_SEGMENT(REQ_SEGMENT), .REP(REP),
        .TRANSITION_MODE(TRANSITION_MODE), .TRANSITION_VALUE(TRANSITION_VALUE),
        .SYS_TIME(SYS_TIME), .GPIO_IN(GPIO_IN), .LOOP_END(LOOP_END), .SEGMENT(SEGMENT),
        .STOP(STOP), .PENDING(PENDING), .SWAP(SWAP), .INVALID(INVALID)
    );

    always #5 CLK = ~CLK;

    // Reference model: a held request plus a remaining-loop budget.
    bit          m_seg, m_stop, m_pend, m_swap, m_inv;
    bit          m_wait, m_ext, m_inf, m_done;
    int          m_left;
    bit          r_seg;
    logic [RW-1:0] r_rep;
    logic [7:0]  r_mode;
    logic [63:0] r_val;

    function automatic bit supported(input logic [7:0] m);
        return (m == 8'h00) || (m == 8'h01) || (m == 8'hF0) || (GpioEn && m == 8'h02);
    endfunction

    function automatic bit trig_met();
        logic [SW-1:0] tv;
        logic [1:0]    gi;
        tv = r_val[SW-1:0];
        gi = r_val[1:0];
        if (r_mode == 8'h00) return LOOP_END;
        if (r_mode == 8'h01) return SYS_TIME >= tv;
        if (r_mode == 8'h02) return GPIO_IN[gi];
        return 1'b1;
    endfunction

    function automatic logic [4:0] exp_vec();
        return {m_seg, m_stop, m_pend, m_swap, m_inv};
    endfunction

    function automatic logic [4:0] obs_vec();
        return {SEGMENT, STOP, PENDING, SWAP, INVALID};
    endfunction

    task automatic model_step();
        m_swap = 1'b0;
        m_inv  = 1'b0;
        if (RST) begin
            m_seg = 0; m_stop = 0; m_pend = 0; m_wait = 0; m_ext = 0; m_inf = 1; m_done = 0;
        end else if (UPDATE) begin
            if (supported(TRANSITION_MODE)) begin
                r_seg = REQ_SEGMENT; r_rep = REP; r_mode = TRANSITION_MODE;
                r_val = TRANSITION_VALUE; m_wait = 1; m_pend = 1;
            end else begin
                m_inv = 1;
            end
        end else if (m_wait) begin
            if (trig_met()) begin
                m_seg = r_seg; m_swap = 1; m_pend = 0; m_stop = 0; m_wait = 0; m_done = 0;
                m_ext = (r_mode == 8'hF0);
                m_inf = (r_rep == {RW{1'b1}});
                m_left = int'(r_rep) + 1;
            end
        end else if (LOOP_END && !m_done) begin
            if (m_ext) begin
                m_seg = !m_seg; m_swap = 1;
            end else if (!m_inf) begin
                m_left--;
                if (m_left == 0) begin
                    m_stop = 1; m_done = 1;
                end
            end
        end
    endtask

    // One clock: model consumes the sampled inputs, pulses drop, time advances.
    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        UPDATE   = 1'b0;
        LOOP_END = 1'b0;
        SYS_TIME = SYS_TIME + SW'(1);
    endtask

    task automatic drive_update(input bit seg, input logic [RW-1:0] rep, input logic [7:0] mode,
                                input logic [63:0] val);
        UPDATE = 1'b1; REQ_SEGMENT = seg; REP = rep; TRANSITION_MODE = mode;
        TRANSITION_VALUE = val;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        drive_update(1'b1, 16'd3, 8'hF0, 64'd0);
        cycle();
        n_checks++;
        if (obs_vec() !== 5'b00000) begin
            n_fail++; $display("FAIL reset_state got=%b exp=%b", obs_vec(), 5'b00000);
        end
        RST = 1'b0;
        cycle();
        n_checks++;
        if (obs_vec() !== 5'b00000 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL update_during_reset got=%b exp=%b", obs_vec(), 5'b00000);
        end
    endtask

    task automatic test_sync_infinite();
        drive_update(1'b1, 16'hFFFF, 8'h00, 64'd0);
        cycle();
        n_checks++;
        if (PENDING !== 1'b1 || SEGMENT !== 1'b0) begin
            n_fail++; $display("FAIL sync_pending got=%b exp=pend1 seg0", obs_vec());
        end
        for (int i = 0; i < 19; i++) begin
            cycle();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL sync_wait got=%b exp=%b", obs_vec(), exp_vec());
            end
        end
        LOOP_END = 1'b1;
        cycle();
        n_checks++;
        if (obs_vec() !== 5'b10010) begin
            n_fail++; $display("FAIL sync_swap got=%b exp=%b", obs_vec(), 5'b10010);
        end
        cycle();
        n_checks++;
        if (obs_vec() !== 5'b10000) begin
            n_fail++; $display("FAIL sync_swap_one_cycle got=%b exp=%b", obs_vec(), 5'b10000);
        end
    endtask

    task automatic test_finite();
        drive_update(1'b1, 16'd2, 8'h00, 64'd0);
        cycle();
        LOOP_END = 1'b1;
        cycle();
        n_checks++;
        if (SWAP !== 1'b1 || STOP !== 1'b0 || SEGMENT !== 1'b1) begin
            n_fail++; $display("FAIL finite_swap got=%b exp=seg1 swap1 stop0", obs_vec());
        end
        for (int k = 1; k <= 4; k++) begin
            repeat (3) cycle();
            LOOP_END = 1'b1;
            cycle();
            n_checks++;
            if (STOP !== (k >= 3) || SWAP !== 1'b0 || SEGMENT !== 1'b1
                || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL finite_loop%0d got=%b exp_stop=%0d", k, obs_vec(), (k >= 3));
            end
        end
    endtask

    task automatic test_sys_time();
        SYS_TIME = SW'(1000);
        drive_update(1'b0, 16'hFFFF, 8'h01, 64'd1010);
        cycle();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (PENDING !== 1'b1 || SWAP !== 1'b0 || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL systime_wait t=%0d got=%b exp=%b", SYS_TIME, obs_vec(), exp_vec());
            end
            cycle();
        end
        n_checks++;
        if (SYS_TIME !== SW'(1011) || obs_vec() !== 5'b00010) begin
            n_fail++;
            $display("FAIL systime_fire t=%0d got=%b exp=%b", SYS_TIME, obs_vec(), 5'b00010);
        end
        // Target already in the past fires on the first wait cycle.
        drive_update(1'b1, 16'hFFFF, 8'h01, 64'd5);
        cycle();
        cycle();
        n_checks++;
        if (obs_vec() !== 5'b10010) begin
            n_fail++; $display("FAIL systime_past got=%b exp=%b", obs_vec(), 5'b10010);
        end
        drive_update(1'b0, 16'hFFFF, 8'h01, 64'd5);
        cycle();
        cycle();
    endtask

    task automatic test_gpio();
        drive_update(1'b1, 16'hFFFF, 8'h02, 64'd2);
        cycle();
        if (GpioEn) begin
            n_checks++;
            if (obs_vec() !== 5'b00100) begin
                n_fail++; $display("FAIL gpio_pending got=%b exp=%b", obs_vec(), 5'b00100);
            end
            GPIO_IN = 4'b0010;
            cycle();
            GPIO_IN = 4'b0000;
            cycle();
            n_checks++;
            if (obs_vec() !== 5'b00100) begin
                n_fail++; $display("FAIL gpio_wrong_bit got=%b exp=%b", obs_vec(), 5'b00100);
            end
            GPIO_IN = 4'b0100;
            cycle();
            GPIO_IN = 4'b0000;
            n_checks++;
            if (obs_vec() !== 5'b10010) begin
                n_fail++; $display("FAIL gpio_swap got=%b exp=%b", obs_vec(), 5'b10010);
            end
        end else begin
            n_checks++;
            if (obs_vec() !== 5'b00001) begin
                n_fail++; $display("FAIL gpio_invalid got=%b exp=%b", obs_vec(), 5'b00001);
            end
            cycle();
            n_checks++;
            if (obs_vec() !== 5'b00000) begin
                n_fail++; $display("FAIL gpio_invalid_clr got=%b exp=%b", obs_vec(), 5'b00000);
            end
        end
    endtask

    task automatic test_ext();
        drive_update(1'b1, 16'd0, 8'hF0, 64'd0);
        cycle();
        n_checks++;
        if (PENDING !== 1'b1 || SWAP !== 1'b0) begin
            n_fail++; $display("FAIL ext_pending got=%b exp=pend1 swap0", obs_vec());
        end
        cycle();
        n_checks++;
        if (obs_vec() !== 5'b10010) begin
            n_fail++; $display("FAIL ext_first got=%b exp=%b", obs_vec(), 5'b10010);
        end
        for (int k = 0; k < 3; k++) begin
            repeat (2) cycle();
            LOOP_END = 1'b1;
            cycle();
            n_checks++;
            if (SEGMENT !== (k == 1) || SWAP !== 1'b1 || STOP !== 1'b0) begin
                n_fail++;
                $display("FAIL ext_toggle%0d got=%b exp_seg=%0d swap=1", k, obs_vec(), (k == 1));
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        drive_update(1'b1, 16'hFFFF, 8'h01, 64'(SYS_TIME) + 64'd10);
        cycle();
        repeat (3) cycle();
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        n_checks++;
        if (obs_vec() !== 5'b00000) begin
            n_fail++; $display("FAIL rst_mid_wait got=%b exp=%b", obs_vec(), 5'b00000);
        end
        for (int i = 0; i < 15; i++) begin
            cycle();
            n_checks++;
            if (obs_vec() !== 5'b00000 || obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL rst_no_swap got=%b exp=%b", obs_vec(), 5'b00000);
            end
        end
        drive_update(1'b1, 16'd1, 8'h07, 64'd0);
        cycle();
        n_checks++;
        if (obs_vec() !== 5'b00001) begin
            n_fail++; $display("FAIL bad_mode got=%b exp=%b", obs_vec(), 5'b00001);
        end
        cycle();
        n_checks++;
        if (obs_vec() !== 5'b00000) begin
            n_fail++; $display("FAIL bad_mode_clr got=%b exp=%b", obs_vec(), 5'b00000);
        end
    endtask

    task automatic test_random();
        int k;
        for (int i = 0; i < 4000; i++) begin
            RST      = ($urandom_range(0, 299) == 0);
            LOOP_END = ($urandom_range(0, 3) == 0);
            GPIO_IN  = 4'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                UPDATE = 1'b1;
                REQ_SEGMENT = 1'($urandom);
                case ($urandom_range(0, 5))
                    0: TRANSITION_MODE = 8'h00;
                    1: TRANSITION_MODE = 8'h01;
                    2: TRANSITION_MODE = 8'h02;
                    3: TRANSITION_MODE = 8'hF0;
                    4: TRANSITION_MODE = 8'h07;
                    default: TRANSITION_MODE = 8'($urandom);
                endcase
                k = $urandom_range(0, 4);
                REP = (k == 4) ? {RW{1'b1}} : RW'(k);
                TRANSITION_VALUE = {8'($urandom),
                                    SYS_TIME + SW'($urandom_range(0, 40)) - SW'(8)};
            end
            cycle();
            RST = 1'b0;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random_cyc%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sync_infinite();
        test_finite();
        test_sys_time();
        test_gpio();
        test_ext();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/segment_switch_ctl.md
SEGMENT_SWITCH_CTL -- requirements
Module: segment_switch_ctl

Interface
REQ-001 SHALL have parameter SysTimeWidth, default 56: width of the system-time bus and of the compared transition value.
REQ-002 SHALL have parameter RepWidth, default 16: width of the repeat count; all-ones means infinite.
REQ-003 SHALL use one clock; reset is synchronous and active-high. Ports in order:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous active-high reset.
- UPDATE  in  1  one-cycle pulse; latches REQ_SEGMENT, REP, TRANSITION_MODE, TRANSITION_VALUE.
- REQ_SEGMENT  in  1  requested segment.
- REP  in  RepWidth  loop count of the requested segment.
- TRANSITION_MODE  in  8  0x00 SYNC_IDX, 0x01 SYS_TIME, 0x02 GPIO, 0xF0 EXT.
- TRANSITION_VALUE  in  64  trigger operand.
- SYS_TIME  in  SysTimeWidth  free-running system time.
- GPIO_IN  in  4  synchronised GPIO levels.
- LOOP_END  in  1  one-cycle pulse from the sampler when its index wraps to 0.
- SEGMENT  out  1  active read segment.
- STOP  out  1  sampler hold request; finite repeat exhausted.
- PENDING  out  1  request latched, trigger not yet met.
- SWAP  out  1  one-cycle pulse on every SEGMENT change.
- INVALID  out  1  one-cycle pulse when UPDATE carries an unsupported mode.

Function
REQ-004 SHALL implement states WAIT_START, RUN_INFINITE, RUN_FINITE, STOPPED, EXT_SWAP.
REQ-005 On UPDATE with a supported mode, SHALL latch all request fields and enter WAIT_START with PENDING=1 on the next cycle, from any state.
REQ-006 An unsupported mode on UPDATE SHALL pulse INVALID for one cycle, drop the request and leave state and outputs unchanged.
REQ-007 In WAIT_START the trigger SHALL be, per mode:
- SYNC_IDX: LOOP_END=1.
- SYS_TIME: SYS_TIME >= TRANSITION_VALUE[SysTimeWidth-1:0], unsigned.
- GPIO: GPIO_IN[TRANSITION_VALUE[1:0]]=1.
- EXT: met unconditionally.
REQ-008 When the trigger is met in cycle N, in cycle N+1 SHALL:
- set SEGMENT = latched segment and pulse SWAP (pulse even if the value is unchanged);
- clear PENDING and STOP and zero the loop counter;
- enter EXT_SWAP if the mode is EXT, else RUN_INFINITE if REP is all-ones, else RUN_FINITE.
REQ-009 A SYS_TIME trigger already satisfied at latch time SHALL fire in the first WAIT_START cycle.
REQ-010 RUN_FINITE SHALL count LOOP_END pulses in a RepWidth counter. A LOOP_END while counter==REP SHALL set STOP=1 in the next cycle and enter STOPPED, so REP=0 gives exactly one loop.
REQ-011 STOPPED SHALL hold SEGMENT and STOP=1 and ignore LOOP_END until the next valid UPDATE.
REQ-012 EXT_SWAP SHALL invert SEGMENT and pulse SWAP on each LOOP_END; STOP stays 0.
REQ-013 UPDATE coinciding with a trigger or LOOP_END SHALL take priority: that event is discarded and the new request latched.
REQ-014 UPDATE during WAIT_START SHALL replace the pending request; no swap occurs for the replaced request.
REQ-015 LOOP_END in WAIT_START SHALL not advance the loop counter except as a SYNC_IDX trigger.
REQ-016 SWAP and INVALID SHALL never exceed one cycle per event; all outputs SHALL be registered.

Reset
REQ-017 RST=1 SHALL set SEGMENT=0, STOP=0, PENDING=0, SWAP=0, INVALID=0, loop counter=0 and state RUN_INFINITE on the next edge.
REQ-018 RST SHALL discard any pending request; after reset release, operation resumes on segment 0 until an UPDATE.
REQ-019 UPDATE asserted together with RST SHALL be ignored.

Configuration
REQ-020 With macro SEGMENT_SWITCH_GPIO_EN defined, mode 0x02 (GPIO) SHALL be supported as in REQ-007.
REQ-021 Without SEGMENT_SWITCH_GPIO_EN, mode 0x02 SHALL be unsupported per REQ-006, and GPIO_IN SHALL remain a port with no logic attached.

Verification
REQ-022 Benches SHALL cover the following directed scenarios:
- UPDATE seg=1, REP=0xFFFF, SYNC_IDX; LOOP_END 20 cycles later -> SEGMENT=1 and SWAP pulse one cycle after LOOP_END; STOP stays 0.
- UPDATE seg=1, REP=2, SYNC_IDX; then 4 further LOOP_END -> STOP=1 one cycle after the 3rd post-swap LOOP_END; 4th LOOP_END causes no change.
- SYS_TIME=1000, UPDATE mode SYS_TIME, value 1010 -> PENDING=1 until SYS_TIME=1010; SEGMENT changes at the cycle where SYS_TIME=1011.
- UPDATE GPIO value=2; pulse GPIO_IN[1], then GPIO_IN[2] -> no swap on bit 1, swap on bit 2 (with macro); without macro -> INVALID pulse, PENDING=0.
- UPDATE EXT, seg=1 -> SEGMENT=1 after 2 cycles; then 3 LOOP_END -> SEGMENT toggles 0,1,0 with 3 SWAP pulses.
- Pending SYS_TIME request plus RST mid-wait -> SEGMENT=0, PENDING=0; later SYS_TIME match causes no swap. Also UPDATE mode 0x07 -> INVALID pulse, state unchanged.
